// File: rtl/npu_pkg.sv
// Shared NPU types: tile-control states, PE precision modes and tile timing helpers.
package npu_pkg;

  typedef enum logic [0:0] {
    PREC_INT8 = 1'b0,
    PREC_INT4 = 1'b1
  } precision_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } tile_state_e;

  // Zero-injection cycles needed for the last beat to cross the whole skewed array.
  function automatic int unsigned flush_cycles(input int unsigned rows, input int unsigned cols);
    return rows + cols + 32'd1;
  endfunction

endpackage

// File: rtl/pe.sv
// Output-stationary MAC processing element: forwards A right and B down, accumulates A*B.
module pe
  import npu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc_clear,
  input  logic                  compute_enable,
  input  logic                  drain_enable,
  input  precision_mode_t       precision_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [ACC_WIDTH-1:0]  b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [ACC_WIDTH-1:0]  b_out,
  output logic [ACC_WIDTH-1:0]  acc_out
);

  logic signed [DATA_WIDTH-1:0]   a_op;
  logic signed [DATA_WIDTH-1:0]   b_op;
  logic signed [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    a_op = a_in;
    b_op = b_in[DATA_WIDTH-1:0];
    if (precision_mode == PREC_INT4) begin
      a_op = {{(DATA_WIDTH-4){a_in[3]}}, a_in[3:0]};
      b_op = {{(DATA_WIDTH-4){b_in[3]}}, b_in[3:0]};
    end
    prod = (2*DATA_WIDTH)'(a_op) * (2*DATA_WIDTH)'(b_op);
  end

  // Drain mode shifts accumulators down the column through the B path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out   <= '0;
      b_out   <= '0;
      acc_out <= '0;
    end else if (acc_clear) begin
      a_out   <= '0;
      b_out   <= '0;
      acc_out <= '0;
    end else if (drain_enable) begin
      b_out   <= acc_out;
      acc_out <= b_in;
    end else if (compute_enable) begin
      a_out   <= a_in;
      b_out   <= b_in;
      acc_out <= acc_out + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/skew_delay_line.sv
// Per-lane staircase delay: lane i is delayed i cycles, zero-filled, synchronously clearable.
module skew_delay_line #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                en,
  input  logic [LANES*DW-1:0] din,
  output logic [LANES*DW-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign dout[DW-1:0] = din[DW-1:0];
    end else begin : g_dly
      logic [DW-1:0] stage [i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned j = 0; j < i; j++) stage[j] <= '0;
        end else if (clear) begin
          for (int unsigned j = 0; j < i; j++) stage[j] <= '0;
        end else if (en) begin
          stage[0] <= din[i*DW +: DW];
          for (int unsigned j = 1; j < i; j++) stage[j] <= stage[j-1];
        end
      end

      assign dout[i*DW +: DW] = stage[i-1];
    end
  end

endmodule

// File: rtl/systolic_tile_engine.sv
// ROWSxCOLS output-stationary GEMM tile engine with input skewing, tile FSM and row-serial drain.
module systolic_tile_engine
  import npu_pkg::*;
#(
  parameter  int unsigned ROWS       = 4,
  parameter  int unsigned COLS       = 4,
  parameter  int unsigned K_MAX      = 256,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned ACC_WIDTH  = 32,
  localparam int unsigned KW         = $clog2(K_MAX + 1),
  localparam int unsigned RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [KW-1:0]              k_len,
  input  precision_mode_t            precision_mode,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  input  logic [COLS*DATA_WIDTH-1:0] b_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RW-1:0]              out_row,
  output logic [COLS*ACC_WIDTH-1:0]  out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned FLUSH_CYC = flush_cycles(ROWS, COLS);
  localparam int unsigned FW        = $clog2(FLUSH_CYC + 1);

  tile_state_e     state, state_nxt;
  logic [KW-1:0]   k_lat, beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row_cnt;
  precision_mode_t prec_lat;

  logic acc_clear, compute_enable, skew_clear;
  logic beat_hs, last_beat, flush_end, row_hs;

  assign beat_hs   = a_valid & a_ready;
  assign last_beat = (beat_cnt == k_lat - KW'(1));
  assign flush_end = (flush_cnt == FW'(FLUSH_CYC - 1));
  assign row_hs    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = (k_lat == '0) ? ST_DRAIN : ST_FEED;
      ST_FEED:  if (beat_hs && last_beat) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (row_hs && out_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    busy           = (state != ST_IDLE);
    a_ready        = (state == ST_FEED) && !abort;
    compute_enable = (state == ST_FEED) || (state == ST_FLUSH);
    acc_clear      = (state == ST_CLEAR) || abort;
    skew_clear     = (state == ST_CLEAR) || abort;
    out_valid      = (state == ST_DRAIN);
    out_last       = (state == ST_DRAIN) && (row_cnt == RW'(ROWS - 1));
    out_row        = (state == ST_DRAIN) ? row_cnt : '0;
    done           = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_lat     <= '0;
      prec_lat  <= PREC_INT8;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      if (state == ST_IDLE && start && !abort) begin
        k_lat    <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
        prec_lat <= precision_mode;
      end

      if (abort || state != ST_FEED) beat_cnt <= '0;
      else if (beat_hs)              beat_cnt <= beat_cnt + KW'(1);

      if (abort || state != ST_FLUSH) flush_cnt <= '0;
      else                            flush_cnt <= flush_cnt + FW'(1);

      if (abort || state != ST_DRAIN) row_cnt <= '0;
      else if (row_hs && !out_last)   row_cnt <= row_cnt + RW'(1);
    end
  end

  // Non-handshake cycles inject zeros so bubbles and flush add nothing to the sums.
  logic [ROWS*DATA_WIDTH-1:0] a_edge, a_skew;
  logic [COLS*DATA_WIDTH-1:0] b_edge, b_skew;

  assign a_edge = beat_hs ? a_data : '0;
  assign b_edge = beat_hs ? b_data : '0;

  skew_delay_line #(.LANES(ROWS), .DW(DATA_WIDTH)) u_a_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (skew_clear),
    .en    (compute_enable),
    .din   (a_edge),
    .dout  (a_skew)
  );

  skew_delay_line #(.LANES(COLS), .DW(DATA_WIDTH)) u_b_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (skew_clear),
    .en    (compute_enable),
    .din   (b_edge),
    .dout  (b_skew)
  );

  logic [DATA_WIDTH-1:0] h_bus    [ROWS][COLS+1];
  logic [ACC_WIDTH-1:0]  v_bus    [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  acc_grid [ROWS][COLS];

  logic [ROWS*DATA_WIDTH-1:0] unused_a_tail;
  logic [COLS*ACC_WIDTH-1:0]  unused_b_tail;

  for (genvar r = 0; r < ROWS; r++) begin : g_row_edge
    assign h_bus[r][0] = a_skew[r*DATA_WIDTH +: DATA_WIDTH];
    assign unused_a_tail[r*DATA_WIDTH +: DATA_WIDTH] = h_bus[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_edge
    assign v_bus[0][c] = ACC_WIDTH'(b_skew[c*DATA_WIDTH +: DATA_WIDTH]);
    assign unused_b_tail[c*ACC_WIDTH +: ACC_WIDTH] = v_bus[ROWS][c];
    assign out_data[c*ACC_WIDTH +: ACC_WIDTH] = out_valid ? acc_grid[row_cnt][c] : '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk            (clk),
        .rst_n          (rst_n),
        .acc_clear      (acc_clear),
        .compute_enable (compute_enable),
        .drain_enable   (1'b0),
        .precision_mode (prec_lat),
        .a_in           (h_bus[r][c]),
        .b_in           (v_bus[r][c]),
        .a_out          (h_bus[r][c+1]),
        .b_out          (v_bus[r+1][c]),
        .acc_out        (acc_grid[r][c])
      );
    end
  end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Randomised self-checking bench for systolic_tile_engine (4x4 and 2x8 instances).
module tb_systolic_tile_engine;
  import npu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int KMAX = 256;
  localparam int KW = 9;
  localparam int FC4 = 9;
  localparam int FC2 = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  int checks = 0;
  int errors = 0;
  precision_mode_t pmode;

  logic start, abort, a_valid, a_ready, out_valid, out_ready, out_last, busy, done;
  logic [KW-1:0]   k_len;
  logic [4*DW-1:0] a_data, b_data;
  logic [1:0]      out_row;
  logic [4*AW-1:0] out_data;

  systolic_tile_engine #(.ROWS(4), .COLS(4), .K_MAX(KMAX), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_len(k_len),
    .precision_mode(pmode), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  logic s2_start, s2_abort, s2_a_valid, s2_a_ready, s2_out_valid, s2_out_ready;
  logic s2_out_last, s2_busy, s2_done;
  logic [KW-1:0]   s2_k_len;
  logic [2*DW-1:0] s2_a_data;
  logic [8*DW-1:0] s2_b_data;
  logic [0:0]      s2_out_row;
  logic [8*AW-1:0] s2_out_data;

  systolic_tile_engine #(.ROWS(2), .COLS(8), .K_MAX(KMAX), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .abort(s2_abort), .k_len(s2_k_len),
    .precision_mode(pmode), .a_valid(s2_a_valid), .a_ready(s2_a_ready), .a_data(s2_a_data),
    .b_data(s2_b_data), .out_valid(s2_out_valid), .out_ready(s2_out_ready), .out_row(s2_out_row),
    .out_data(s2_out_data), .out_last(s2_out_last), .busy(s2_busy), .done(s2_done)
  );

  // Reference matrices and golden results (plain integer GEMM, 32-bit wrap)
  byte a_m [4][KMAX];
  byte b_m [KMAX][4];
  int  expc [4][4];

  logic [AW-1:0] got [4][4];
  int got_row [4];
  bit got_last [4];
  int hold_bad, done_cnt, lat;
  bit tmo;
  int unsigned s_cyc;

  task automatic model(input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int acc = 0;
        for (int i = 0; i < k; i++) acc += int'(a_m[r][i]) * int'(b_m[i][c]);
        expc[r][c] = acc;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < KMAX; i++) begin
        a_m[r][i] = byte'($urandom);
        b_m[i][r] = byte'($urandom);
      end
  endtask

  task automatic start_tile(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    s_cyc = cyc;
    k_len = KW'($urandom);
  endtask

  // mode 0: a_valid always high; 1: 1-0-0 repeating over FEED cycles; 2: random
  task automatic feed(input int k, input int mode);
    int idx = 0;
    int fc = 0;
    int n = 0;
    bit v;
    while (idx < k && n < 5000) begin
      @(negedge clk);
      n++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (fc % 3 == 0) : ($urandom_range(0, 2) != 0);
      a_valid = v;
      for (int l = 0; l < 4; l++) begin
        a_data[l*DW +: DW] = v ? a_m[l][idx] : DW'($urandom);
        b_data[l*DW +: DW] = v ? b_m[idx][l] : DW'($urandom);
      end
      if (a_ready) begin
        fc++;
        if (v) idx++;
      end
    end
    if (idx < k) tmo = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    a_data = $urandom;
    b_data = $urandom;
  endtask

  task automatic collect(input int stall);
    int n = 0;
    hold_bad = 0;
    done_cnt = 0;
    lat = 0;
    while (!out_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      tmo = 1'b1;
      return;
    end
    lat = int'(cyc - s_cyc) + 1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] r0;
      logic [4*AW-1:0] d0;
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        r0 = out_row;
        d0 = out_data;
        @(negedge clk);
        if (!out_valid || out_row !== r0 || out_data !== d0) hold_bad++;
      end
      got_row[i] = int'(out_row);
      got_last[i] = out_last;
      for (int c = 0; c < 4; c++) got[i][c] = out_data[c*AW +: AW];
      if (!out_valid) tmo = 1'b1;
      if (done) done_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
    checks++; if (out_data !== '0 || out_last !== 1'b0 || out_row !== 2'd0) begin
      errors++; $display("FAIL reset_out_bus: got data %h last %b row %0d expected all zero", out_data, out_last, out_row);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || s2_busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy %b/%b expected 0/0", busy, s2_busy);
    end
  endtask

  task automatic test_identity(input string name, input int mode, input int exp_lat);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        a_m[r][k] = (r == k) ? 8'sd1 : 8'sd0;
        b_m[k][r] = byte'(k * 4 + r);
      end
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) b_m[k][c] = byte'(k * 4 + c);
    model(4);
    tmo = 1'b0;
    start_tile(4);
    feed(4, mode);
    collect(0);
    checks++; if (tmo) begin errors++; $display("FAIL %s_timeout: got timeout expected completion", name); end
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (got[i][c] !== AW'(i * 4 + c)) begin
          errors++; $display("FAIL %s_data r%0d c%0d: got %0d expected %0d", name, i, c, $signed(got[i][c]), i * 4 + c);
        end
      end
      checks++; if (got_row[i] != i || got_last[i] !== (i == 3)) begin
        errors++; $display("FAIL %s_row %0d: got row %0d last %b expected row %0d last %b", name, i, got_row[i], got_last[i], i, i == 3);
      end
    end
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done: got %0d pulses expected 1", name, done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: got busy %b expected 0", name, busy); end
  endtask

  task automatic test_backpressure();
    fill_random();
    model(4);
    tmo = 1'b0;
    start_tile(4);
    feed(4, 0);
    collect(3);
    checks++; if (tmo) begin errors++; $display("FAIL bp_timeout: got timeout expected completion"); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stall cycles expected 0", hold_bad); end
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (got[i][c] !== AW'(expc[i][c])) begin
          errors++; $display("FAIL bp_data r%0d c%0d: got %0d expected %0d", i, c, $signed(got[i][c]), expc[i][c]);
        end
      end
      checks++; if (got_row[i] != i || got_last[i] !== (i == 3)) begin
        errors++; $display("FAIL bp_row %0d: got row %0d last %b expected row %0d last %b", i, got_row[i], got_last[i], i, i == 3);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_signed_depth();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < KMAX; i++) begin
        a_m[r][i] = -8'sd1;
        b_m[i][r] = 8'sd3;
      end
    // k_len of 256 and an over-range 300 (clamped) must both give -768
    for (int pass = 0; pass < 2; pass++) begin
      int kl = (pass == 0) ? 256 : 300;
      tmo = 1'b0;
      start_tile(kl);
      feed(256, 0);
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL depth_clamp k%0d: got a_ready %b after 256 beats expected 0", kl, a_ready); end
      collect(0);
      checks++; if (tmo) begin errors++; $display("FAIL depth_timeout k%0d: got timeout expected completion", kl); end
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 4; c++) begin
          checks++; if (got[i][c] !== AW'(-768)) begin
            errors++; $display("FAIL depth_data k%0d r%0d c%0d: got %0d expected -768", kl, i, c, $signed(got[i][c]));
          end
        end
      checks++; if (lat != 2 + 256 + FC4) begin errors++; $display("FAIL depth_latency k%0d: got %0d expected %0d", kl, lat, 2 + 256 + FC4); end
    end
    tmo = 1'b0;
    start_tile(0);
    collect(0);
    checks++; if (tmo) begin errors++; $display("FAIL zero_k_timeout: got timeout expected completion"); end
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 4; c++) begin
        checks++; if (got[i][c] !== '0) begin
          errors++; $display("FAIL zero_k_data r%0d c%0d: got %0d expected 0", i, c, $signed(got[i][c]));
        end
      end
    checks++; if (done_cnt != 1 || got_last[3] !== 1'b1) begin
      errors++; $display("FAIL zero_k_done: got %0d pulses last %b expected 1 pulse last 1", done_cnt, got_last[3]);
    end
  endtask

  task automatic test_abort();
    int dseen = 0;
    fill_random();
    tmo = 1'b0;
    start_tile(4);
    feed(2, 0);
    abort = 1'b1;
    a_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    a_valid = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy %b out_valid %b expected 0 0", busy, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      if (done) dseen++;
      @(negedge clk);
    end
    checks++; if (dseen != 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", dseen); end
    start = 1'b1;
    abort = 1'b1;
    k_len = 9'd4;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_start: got busy %b expected 0", busy); end
    for (int r = 0; r < 4; r++) begin
      a_m[r][0] = 8'sd2;
      b_m[0][r] = 8'sd5;
    end
    model(1);
    start_tile(1);
    feed(1, 0);
    collect(0);
    checks++; if (tmo) begin errors++; $display("FAIL abort_retile_timeout: got timeout expected completion"); end
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 4; c++) begin
        checks++; if (got[i][c] !== AW'(expc[i][c])) begin
          errors++; $display("FAIL abort_retile_data r%0d c%0d: got %0d expected %0d", i, c, $signed(got[i][c]), expc[i][c]);
        end
      end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int k = $urandom_range(1, 24);
      int st = $urandom_range(0, 2);
      fill_random();
      model(k);
      tmo = 1'b0;
      start_tile(k);
      feed(k, 2);
      collect(st);
      checks++; if (tmo || hold_bad != 0 || done_cnt != 1) begin
        errors++; $display("FAIL rand%0d_ctrl: got timeout %b hold_bad %0d done %0d expected 0 0 1", it, tmo, hold_bad, done_cnt);
      end
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 4; c++) begin
          checks++; if (got[i][c] !== AW'(expc[i][c])) begin
            errors++; $display("FAIL rand%0d_data k%0d r%0d c%0d: got %0d expected %0d", it, k, i, c, $signed(got[i][c]), expc[i][c]);
          end
        end
    end
  endtask

  task automatic test_nonsquare();
    byte a2 [2][17];
    byte b2 [17][8];
    int e2 [2][8];
    int idx = 0;
    int n = 0;
    int l2;
    int dseen = 0;
    int unsigned s0;
    for (int i = 0; i < 17; i++) begin
      for (int r = 0; r < 2; r++) a2[r][i] = byte'($urandom);
      for (int c = 0; c < 8; c++) b2[i][c] = byte'($urandom);
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) begin
        e2[r][c] = 0;
        for (int i = 0; i < 17; i++) e2[r][c] += int'(a2[r][i]) * int'(b2[i][c]);
      end
    @(negedge clk);
    s2_start = 1'b1;
    s2_k_len = 9'd17;
    @(negedge clk);
    s2_start = 1'b0;
    s0 = cyc;
    while (idx < 17 && n < 500) begin
      @(negedge clk);
      n++;
      s2_start = 1'b1;
      s2_k_len = 9'd3;
      s2_a_valid = 1'b1;
      for (int r = 0; r < 2; r++) s2_a_data[r*DW +: DW] = a2[r][idx];
      for (int c = 0; c < 8; c++) s2_b_data[c*DW +: DW] = b2[idx][c];
      if (s2_a_ready) idx++;
    end
    @(negedge clk);
    s2_a_valid = 1'b0;
    s2_start = 1'b0;
    n = 0;
    while (!s2_out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    l2 = int'(cyc - s0) + 1;
    checks++; if (!s2_out_valid) begin errors++; $display("FAIL ns_timeout: got no out_valid expected drain"); end
    checks++; if (l2 != 2 + 17 + FC2) begin errors++; $display("FAIL ns_latency: got %0d expected %0d", l2, 2 + 17 + FC2); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (s2_out_row !== 1'(i) || s2_out_last !== (i == 1) || s2_out_valid !== 1'b1) begin
        errors++; $display("FAIL ns_row %0d: got row %0d last %b valid %b expected row %0d last %b valid 1", i, s2_out_row, s2_out_last, s2_out_valid, i, i == 1);
      end
      for (int c = 0; c < 8; c++) begin
        checks++; if (s2_out_data[c*AW +: AW] !== AW'(e2[i][c])) begin
          errors++; $display("FAIL ns_data r%0d c%0d: got %0d expected %0d", i, c, $signed(s2_out_data[c*AW +: AW]), e2[i][c]);
        end
      end
      s2_out_ready = 1'b1;
      @(negedge clk);
      s2_out_ready = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (s2_done) dseen++;
      @(negedge clk);
    end
    checks++; if (dseen != 1 || s2_busy !== 1'b0) begin
      errors++; $display("FAIL ns_done: got %0d pulses busy %b expected 1 pulse busy 0", dseen, s2_busy);
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got time limit exceeded expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pmode = PREC_INT8;
    start = 1'b0; abort = 1'b0; a_valid = 1'b0; out_ready = 1'b0;
    k_len = '0; a_data = '0; b_data = '0;
    s2_start = 1'b0; s2_abort = 1'b0; s2_a_valid = 1'b0; s2_out_ready = 1'b0;
    s2_k_len = '0; s2_a_data = '0; s2_b_data = '0;
    test_reset();
    test_identity("identity", 0, 2 + 4 + FC4);
    test_identity("bubbles", 1, 2 + 4 + FC4 + 6);
    test_backpressure();
    test_signed_depth();
    test_abort();
    test_random();
    test_nonsquare();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
